// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// ------------
// Arbitrates the single-port data memory between the core MEM stage (port A)
// and an auxiliary requester such as a loader or debug access (port B).
//
// Port A has fixed priority. Port B is protected from starvation by a
// saturating counter of its consecutive denied cycles. When that count reaches
// STARVE_LIMIT, the next cycle is a BOOST cycle in which B is granted once.
// STARVE_LIMIT = 0 turns boosting off, which leaves pure A priority.
//
// Optional feature macro: DMEM_ARB_PERF_EN
//   When defined, the block adds saturating grant and conflict counters.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   core request
//   a_gnt/a_rvalid/a_rdata      core grant and read response
//   b_req/b_we/b_addr/b_wdata   auxiliary request
//   b_gnt/b_rvalid/b_rdata      auxiliary grant and read response
//   stall_m             core request denied this cycle (a_req & ~a_gnt)
//   mem_addr/mem_wdata/mem_we   memory command from the granted port
//   mem_rdata           memory read data, valid one cycle after the address
//   perf_a_cnt, perf_b_cnt, perf_conflict_cnt   (DMEM_ARB_PERF_EN only)
//   dbg_state           arbiter FSM state (0 = NORMAL, 1 = BOOST)
//   dbg_cnt             starvation counter
//
// Handshake: a request is accepted in the cycle its gnt is high. Grant is
// combinational and is never registered. Until it is granted, the requester
// keeps req and all fields stable. A granted read returns rvalid and rdata
// exactly one cycle later. A granted write produces no response.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        stall_m,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0] perf_a_cnt,
  output logic [31:0] perf_b_cnt,
  output logic [31:0] perf_conflict_cnt,
`endif
  output logic [0:0]  dbg_state,
  output logic [7:0]  dbg_cnt
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_BOOST  = 1'b1;

  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);
  localparam logic       BOOST_EN = (STARVE_LIMIT != 0);

  logic [0:0] state, state_next;
  logic [7:0] cnt, cnt_inc, cnt_next;
  logic       boost_enter;
  logic       rd_a, rd_b;

  // Grant selection. Reset blocks every grant. In BOOST, B wins whenever it
  // is requesting. Otherwise A wins and B gets only the cycles A leaves idle.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (state == ST_BOOST && b_req) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  assign stall_m = a_req & ~a_gnt;

  // Starvation counter. BOOST is entered on the edge where the count would
  // reach the limit. B is therefore served in the cycle that immediately
  // follows its L-th denied cycle, so the boost period is L+1 cycles.
  always_comb begin
    cnt_inc = 8'd0;
    if (b_req && !b_gnt) begin
      cnt_inc = (cnt >= LIMIT) ? LIMIT : cnt + 8'd1;
    end
  end

  assign boost_enter = BOOST_EN && (state == ST_NORMAL) && b_req && !b_gnt &&
                       (cnt_inc == LIMIT);

  always_comb begin
    state_next = ST_NORMAL;
    cnt_next   = cnt_inc;
    if (state == ST_NORMAL && boost_enter) begin
      state_next = ST_BOOST;
      cnt_next   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_NORMAL;
      cnt   <= 8'd0;
      rd_a  <= 1'b0;
      rd_b  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rd_a  <= a_gnt & ~a_we;
      rd_b  <= b_gnt & ~b_we;
    end
  end

  // Memory command comes from the granted port. When nothing is granted it is
  // zero, so the bus never shows a stale address.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_we    = 1'b0;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_we    = a_we;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_we    = b_we;
    end
  end

  // Response routing. Reset arriving while a read is in flight suppresses that
  // read's response. The response is then lost.
  assign a_rvalid = rd_a & ~rst;
  assign b_rvalid = rd_b & ~rst;
  assign a_rdata  = a_rvalid ? mem_rdata : 32'd0;
  assign b_rdata  = b_rvalid ? mem_rdata : 32'd0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_a_cnt        <= 32'd0;
      perf_b_cnt        <= 32'd0;
      perf_conflict_cnt <= 32'd0;
    end else begin
      if (a_gnt && perf_a_cnt != 32'hFFFF_FFFF) begin
        perf_a_cnt <= perf_a_cnt + 32'd1;
      end
      if (b_gnt && perf_b_cnt != 32'hFFFF_FFFF) begin
        perf_b_cnt <= perf_b_cnt + 32'd1;
      end
      if (a_req && b_req && perf_conflict_cnt != 32'hFFFF_FFFF) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`endif

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It drives two instances from the same stimulus:
// u0 uses STARVE_LIMIT=4 and u1 uses STARVE_LIMIT=0 (pure priority). The bench
// owns a small memory for each instance. A reference model of the arbitration
// rules is checked against both instances on every cycle. Directed literal
// checks pin the model's key behaviours.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

  logic [1:0]  a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, stall_o, mem_we_o;
  logic [31:0] a_rdata_o [2];
  logic [31:0] b_rdata_o [2];
  logic [31:0] mem_addr_o [2];
  logic [31:0] mem_wdata_o [2];
  logic [31:0] mem_rdata_i [2];
  logic [0:0]  dbg_state_o [2];
  logic [7:0]  dbg_cnt_o [2];
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_a_o [2];
  logic [31:0] perf_b_o [2];
  logic [31:0] perf_c_o [2];
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dmem_arbiter #(.STARVE_LIMIT(4)) u0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_o[0]), .a_rvalid(a_rvalid_o[0]), .a_rdata(a_rdata_o[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_o[0]), .b_rvalid(b_rvalid_o[0]), .b_rdata(b_rdata_o[0]),
    .stall_m(stall_o[0]),
    .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_we(mem_we_o[0]),
    .mem_rdata(mem_rdata_i[0]),
`ifdef DMEM_ARB_PERF_EN
    .perf_a_cnt(perf_a_o[0]), .perf_b_cnt(perf_b_o[0]),
    .perf_conflict_cnt(perf_c_o[0]),
`endif
    .dbg_state(dbg_state_o[0]), .dbg_cnt(dbg_cnt_o[0])
  );

  dmem_arbiter #(.STARVE_LIMIT(0)) u1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_o[1]), .a_rvalid(a_rvalid_o[1]), .a_rdata(a_rdata_o[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_o[1]), .b_rvalid(b_rvalid_o[1]), .b_rdata(b_rdata_o[1]),
    .stall_m(stall_o[1]),
    .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_we(mem_we_o[1]),
    .mem_rdata(mem_rdata_i[1]),
`ifdef DMEM_ARB_PERF_EN
    .perf_a_cnt(perf_a_o[1]), .perf_b_cnt(perf_b_o[1]),
    .perf_conflict_cnt(perf_c_o[1]),
`endif
    .dbg_state(dbg_state_o[1]), .dbg_cnt(dbg_cnt_o[1])
  );

  // ---------------- bench memories (1-cycle read latency) ----------------
  logic [31:0] tmem [2][256];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_we_o[i]) tmem[i][mem_addr_o[i][9:2]] <= mem_wdata_o[i];
      mem_rdata_i[i] <= tmem[i][mem_addr_o[i][9:2]];
    end
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // starve[i] = number of consecutive cycles in which B requested and was
  // denied. Once it equals the limit, the following cycle belongs to B.
  int          starve [2];
  bit          mrd_a [2];
  bit          mrd_b [2];
  logic [31:0] mmem [2][256];
  // Each entry is {instance, port_is_b, expected read data}.
  logic [33:0] exp_q [$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   lim;
      bit   boost, eg_a, eg_b, ra, rb;
      logic [31:0] e_addr, e_wdata, e_ard, e_brd;
      logic e_we;
      logic [33:0] ent;
      lim   = (i == 0) ? 4 : 0;
      boost = (lim != 0) && (starve[i] == lim);
      eg_a  = 1'b0;
      eg_b  = 1'b0;
      if (!rst) begin
        if (boost && b_req) eg_b = 1'b1;
        else if (a_req)     eg_a = 1'b1;
        else if (b_req)     eg_b = 1'b1;
      end
      e_addr  = eg_a ? a_addr  : (eg_b ? b_addr  : 32'd0);
      e_wdata = eg_a ? a_wdata : (eg_b ? b_wdata : 32'd0);
      e_we    = eg_a ? a_we    : (eg_b ? b_we    : 1'b0);

      ra = mrd_a[i] && !rst;
      rb = mrd_b[i] && !rst;
      e_ard = 32'd0;
      e_brd = 32'd0;
      if (mrd_a[i] || mrd_b[i]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("u%0d.exp_q_empty", i), 32'd1, 32'd0);
        end else begin
          ent = exp_q.pop_front();
          chk($sformatf("u%0d.exp_q_tag", i), {30'd0, ent[33:32]},
              {30'd0, i[0], mrd_b[i]});
          if (ra) e_ard = ent[31:0];
          if (rb) e_brd = ent[31:0];
        end
      end

      chk($sformatf("u%0d.a_gnt", i),     {31'd0, a_gnt_o[i]},    {31'd0, eg_a});
      chk($sformatf("u%0d.b_gnt", i),     {31'd0, b_gnt_o[i]},    {31'd0, eg_b});
      chk($sformatf("u%0d.stall_m", i),   {31'd0, stall_o[i]},    {31'd0, a_req & ~eg_a});
      chk($sformatf("u%0d.mem_we", i),    {31'd0, mem_we_o[i]},   {31'd0, e_we});
      chk($sformatf("u%0d.mem_addr", i),  mem_addr_o[i],          e_addr);
      chk($sformatf("u%0d.mem_wdata", i), mem_wdata_o[i],         e_wdata);
      chk($sformatf("u%0d.a_rvalid", i),  {31'd0, a_rvalid_o[i]}, {31'd0, ra});
      chk($sformatf("u%0d.b_rvalid", i),  {31'd0, b_rvalid_o[i]}, {31'd0, rb});
      chk($sformatf("u%0d.a_rdata", i),   a_rdata_o[i],           e_ard);
      chk($sformatf("u%0d.b_rdata", i),   b_rdata_o[i],           e_brd);

      // Advance the model to the state after the coming rising edge.
      if (e_we) mmem[i][e_addr[9:2]] = e_wdata;
      if ((eg_a || eg_b) && !e_we) exp_q.push_back({i[0], eg_b, mmem[i][e_addr[9:2]]});
      mrd_a[i] = eg_a && !a_we;
      mrd_b[i] = eg_b && !b_we;
      if (rst || boost || !b_req || eg_b) starve[i] = 0;
      else if (starve[i] < 255) starve[i] = starve[i] + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [31:0] aa,
                       input logic [31:0] ad, input logic br, input logic bw,
                       input logic [31:0] ba, input logic [31:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [19:0] bmask, smask;
    int nb1;
    for (int i = 0; i < 2; i++) begin
      starve[i] = 0; mrd_a[i] = 0; mrd_b[i] = 0;
      for (int k = 0; k < 256; k++) begin
        tmem[i][k] = 32'hA5A5_0000 | 32'(k);
        mmem[i][k] = 32'hA5A5_0000 | 32'(k);
      end
      tmem[i][4] = 32'hDEAD_BEEF;
      mmem[i][4] = 32'hDEAD_BEEF;
    end

    // Reset held two cycles with both ports requesting.
    rst = 1'b1;
    drive(1, 0, 32'h10, 0, 1, 0, 32'h30, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.a_gnt",   {31'd0, a_gnt_o[0]},  32'd0);
      chk("rst.b_gnt",   {31'd0, b_gnt_o[0]},  32'd0);
      chk("rst.mem_we",  {31'd0, mem_we_o[0]}, 32'd0);
      chk("rst.stall_m", {31'd0, stall_o[0]},  32'd1);
      tick;
    end
    rst = 1'b0;

    // Core read of 0x10 is granted first after reset. Data arrives next cycle.
    @(negedge clk);
    chk("core_rd.a_gnt",    {31'd0, a_gnt_o[0]}, 32'd1);
    chk("core_rd.mem_addr", mem_addr_o[0], 32'h10);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("core_rd.a_rvalid", {31'd0, a_rvalid_o[0]}, 32'd1);
    chk("core_rd.a_rdata",  a_rdata_o[0], 32'hDEAD_BEEF);
    chk("core_rd.b_rvalid", {31'd0, b_rvalid_o[0]}, 32'd0);
    tick;

    // B writes 0x20 and then reads it back.
    drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("b_wr.b_gnt",  {31'd0, b_gnt_o[0]},  32'd1);
    chk("b_wr.mem_we", {31'd0, mem_we_o[0]}, 32'd1);
    tick;
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
    @(negedge clk);
    chk("b_rd.mem_we", {31'd0, mem_we_o[0]}, 32'd0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_rd.b_rvalid", {31'd0, b_rvalid_o[0]}, 32'd1);
    chk("b_rd.b_rdata",  b_rdata_o[0], 32'h1234_5678);
    tick;

    // Reads every cycle, alternating between the two ports.
    for (int k = 0; k < 8; k++) begin
      if (k[0]) drive(0, 0, 0, 0, 1, 0, 32'(k * 8 + 4), 0);
      else      drive(1, 0, 32'(k * 8), 0, 0, 0, 0, 0);
      tick;
    end

    // Reset lands on the cycle after a granted read, so the response is lost.
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_inflight.a_rvalid", {31'd0, a_rvalid_o[0]}, 32'd0);
    chk("rst_inflight.a_rdata",  a_rdata_o[0], 32'd0);
    tick;
    rst = 1'b0;
    tick;

    // Starvation, limit 4: both ports request for 20 cycles.
    bmask = '0;
    smask = '0;
    for (int c = 0; c < 20; c++) begin
      drive(1, 0, 32'(c * 4), 0, 1, 0, 32'(c * 4 + 128), 0);
      @(negedge clk);
      bmask[c] = b_gnt_o[0];
      smask[c] = stall_o[0];
      tick;
    end
    chk("starve.b_gnt_cycles",   {12'd0, bmask}, 32'h8_4210);
    chk("starve.stall_m_cycles", {12'd0, smask}, 32'h8_4210);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // Boost cancel: counter reaches the limit, then b_req drops in BOOST.
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
      tick;
    end
    drive(1, 0, 32'h40, 0, 0, 0, 32'h44, 0);
    @(negedge clk);
    chk("cancel.state_boost", {31'd0, dbg_state_o[0]}, 32'd1);
    chk("cancel.a_gnt", {31'd0, a_gnt_o[0]}, 32'd1);
    chk("cancel.b_gnt", {31'd0, b_gnt_o[0]}, 32'd0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("cancel.state_normal", {31'd0, dbg_state_o[0]}, 32'd0);
    chk("cancel.cnt", {24'd0, dbg_cnt_o[0]}, 32'd0);
    tick;

    // Pure priority, limit 0: both ports request for 50 cycles after a reset.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    nb1 = 0;
    for (int c = 0; c < 50; c++) begin
      drive(1, 0, 32'(c * 4), 0, 1, 0, 32'h200, 0);
      @(negedge clk);
      if (b_gnt_o[1]) nb1++;
      tick;
    end
    chk("pure.b_gnt_count", 32'(nb1), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
    chk("perf.conflict", perf_c_o[1], 32'd50);
    chk("perf.a_cnt",    perf_a_o[1], 32'd50);
    chk("perf.b_cnt",    perf_b_o[1], 32'd0);
`endif
    tick;
    tick;

    chk("exp_q.drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory used by the pipelined core's memory stage. Port A is the core MEM stage. Port B is an auxiliary requester such as a program loader or debug access. Each cycle the block grants at most one requester, drives the memory address, write-data and write-enable, and routes the one-cycle-latency read data back to the owner. Port A has fixed priority, with a starvation counter that forces a single grant to port B after a configurable number of denied cycles. Port A's denial is exported as a stall to the hazard unit.

## Interface
Parameters:
- STARVE_LIMIT, default 4: consecutive denied cycles of port B before boost; legal range 0..255; 0 disables boost (pure A priority).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  core request valid.
- a_we  input  1  core write (1) / read (0).
- a_addr  input  32  core byte address.
- a_wdata  input  32  core write data.
- a_gnt  output  1  core request accepted this cycle.
- a_rvalid  output  1  core read data valid.
- a_rdata  output  32  core read data.
- b_req, b_we, b_addr[31:0], b_wdata[31:0]  input  auxiliary request; same meaning as port A.
- b_gnt, b_rvalid, b_rdata[31:0]  output  auxiliary grant and response.
- stall_m  output  1  a_req & ~a_gnt.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  32  memory read data, valid the cycle after the read address is presented.

## Operation
- Grant is combinational from the current-cycle requests and the registered state. Grants are one-hot or zero.
- FSM states:
  - NORMAL: grant A if a_req; otherwise grant B if b_req.
  - BOOST: grant B if b_req, with A denied; if b_req=0, grant A if a_req.
- FSM transitions:
  - NORMAL→BOOST when the starvation counter equals STARVE_LIMIT and STARVE_LIMIT≠0.
  - BOOST→NORMAL unconditionally after one cycle.
- Starvation counter (8-bit):
  - Increments when b_req & ~b_gnt.
  - Clears when b_gnt or ~b_req.
  - Saturates at STARVE_LIMIT.
  - Clears on the entry into BOOST.
- Memory drive:
  - mem_addr and mem_wdata are taken from the granted port.
  - mem_we = granted port's we.
  - With no grant, mem_addr and mem_wdata are 0 and mem_we=0.
- Response tracking:
  - 2-bit registered owner, {rd_a, rd_b}, set on a granted read and cleared otherwise.
  - a_rvalid = rd_a, b_rvalid = rd_b.
  - a_rdata = mem_rdata when rd_a, else 0; b_rdata likewise.
- Writes produce no rvalid.
- Requesters hold request fields stable until granted; the block does not latch ungranted requests.

## Timing
- Reset (rst=1 at a clock edge):
  - State becomes NORMAL, counter 0, rd_a=rd_b=0.
  - Thereafter a_rvalid=b_rvalid=0 and a_rdata=b_rdata=0.
  - While rst=1, a_gnt=b_gnt=0, mem_we=0, mem_addr=mem_wdata=0, and stall_m=a_req.
- Grant latency is 0 cycles. Read latency is 1 cycle: grant at cycle N, rvalid and rdata at N+1. A write takes effect at the edge ending cycle N.
- Back-to-back reads by the same or alternating ports are accepted every cycle; throughput is 1 access per cycle.
- Reset asserted with a read in flight: rvalid for that read is suppressed and the response is lost.
- Simultaneous a_req and b_req in NORMAL with counter < STARVE_LIMIT: A wins.
- Boost pattern with continuous A and B requests and STARVE_LIMIT=L: B is granted once every L+1 cycles.
- b_req dropping during BOOST: no B grant; A is served that cycle if requesting; the FSM returns to NORMAL.

## Configuration
- Macro DMEM_ARB_PERF_EN, defined: adds the following outputs, all cleared by rst:
  - perf_a_cnt[31:0]: A grants, saturating at 0xFFFFFFFF.
  - perf_b_cnt[31:0]: B grants, saturating at 0xFFFFFFFF.
  - perf_conflict_cnt[31:0]: cycles with a_req & b_req, saturating at 0xFFFFFFFF.
- Macro DMEM_ARB_PERF_EN, undefined: these ports and counters do not exist, and arbitration behaviour is identical.

## Test plan
- Reset: hold rst=1 for 2 cycles with a_req=b_req=1 → a_gnt=b_gnt=0, mem_we=0, stall_m=1; after release, A granted in the first cycle.
- Core read: a_req=1, a_we=0, a_addr=0x10, memory holds 0xDEADBEEF there → a_gnt=1 at N; a_rvalid=1, a_rdata=0xDEADBEEF at N+1; b_rvalid=0.
- Write then read from B: b_we=1, b_addr=0x20, b_wdata=0x12345678 with no A activity → mem_we=1 for one cycle; a subsequent B read returns 0x12345678 one cycle after its grant.
- Starvation: STARVE_LIMIT=4, a_req and b_req held high for 20 cycles → b_gnt in cycles 5, 10, 15, 20; stall_m=1 exactly in those cycles.
- Boost cancel: drive the counter to the limit, then drop b_req on the BOOST cycle → a_gnt=1, b_gnt=0, FSM back to NORMAL, counter 0.
- Pure priority: STARVE_LIMIT=0, both requesting for 50 cycles → b_gnt never asserts; with DMEM_ARB_PERF_EN, perf_conflict_cnt=50 and perf_a_cnt=50.
